pit_cfg_seq: RTL

//  Wishbone master sequencer that programs and starts/stops a pit_top slave.
//  On start_i it latches a config set and writes it to the PIT:

---
 rtl/pit_cfg_seq.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/pit_cfg_seq.sv
// pit_cfg_seq: Wishbone master that programs a PIT (CTRL off, MOD, MOD check, CTRL on) or stops it.
// Latency: one entry cycle plus ack wait per transfer; 8 cycles start->done, 2 for stop with zero-wait ack.
// Backpressure: each transfer holds cyc/stb until m_ack_i, or aborts after TIMEOUT cycles without ack.
module pit_cfg_seq #(
  parameter int         DWIDTH     = 16,
  parameter int         COUNT_SIZE = 16,
  parameter logic [2:0] CTRL_ADR   = 3'd0,
  parameter logic [2:0] MOD_ADR    = 3'd1,
  parameter int         TIMEOUT    = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  arst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [COUNT_SIZE-1:0] cfg_mod_i,
  input  logic [3:0]            cfg_pre_i,
  input  logic                  cfg_ien_i,
  input  logic                  cfg_slave_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [2:0]            m_adr_o,
  output logic [DWIDTH-1:0]     m_dat_o,
  input  logic [DWIDTH-1:0]     m_dat_i,
  output logic                  m_we_o,
  output logic                  m_stb_o,
  output logic                  m_cyc_o,
  output logic [1:0]            m_sel_o,
  input  logic                  m_ack_i
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_CTRL0,
    ST_WR_MOD,
    ST_RD_MOD,
    ST_WR_CTRL1,
    ST_WR_STOP
  } state_t;

  // Last count value before a transfer is abandoned; the counter is 8 bits wide.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [2:0]            adr_q, adr_d;
  logic [DWIDTH-1:0]     dat_q, dat_d;
  logic [7:0]            tmo_q, tmo_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  stop_pend_q, stop_pend_d;
  logic [COUNT_SIZE-1:0] mod_q, mod_d;
  logic [3:0]            pre_q, pre_d;
  logic                  ien_q, ien_d;
  logic                  slave_q, slave_d;

  logic [DWIDTH-1:0]     ctrl_dis;
  logic [DWIDTH-1:0]     ctrl_en;
  logic [DWIDTH-1:0]     mod_word;
  logic                  seq_end;

  // Register images built from the latched config; flag_clr is always written as 1.
  always_comb begin
    ctrl_dis                   = '0;
    ctrl_dis[15]               = slave_q;
    ctrl_dis[11:8]             = pre_q;
    ctrl_dis[2]                = 1'b1;
    ctrl_dis[1]                = ien_q;
    ctrl_en                    = ctrl_dis;
    ctrl_en[0]                 = 1'b1;
    mod_word                   = '0;
    mod_word[COUNT_SIZE-1:0]   = mod_q;
  end

  // State and bus registers; reset releases the bus immediately.
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      mod_q       <= '0;
      pre_q       <= '0;
      ien_q       <= 1'b0;
      slave_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      done_q      <= done_d;
      stop_pend_q <= stop_pend_d;
      mod_q       <= mod_d;
      pre_q       <= pre_d;
      ien_q       <= ien_d;
      slave_q     <= slave_d;
    end
  end

  // Next state: each non-idle state spends one cycle with the bus idle, then launches its transfer.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    done_d      = 1'b0;
    stop_pend_d = stop_pend_q;
    mod_d       = mod_q;
    pre_d       = pre_q;
    ien_d       = ien_q;
    slave_d     = slave_q;
    seq_end     = 1'b0;

    if (state_q == ST_IDLE) begin
      // A simultaneous stop beats start; the start and its config are dropped.
      if (stop_i) begin
        state_d = ST_WR_STOP;
      end else if (start_i) begin
        state_d = ST_WR_CTRL0;
        err_d   = 1'b0;
        mod_d   = cfg_mod_i;
        pre_d   = cfg_pre_i;
        ien_d   = cfg_ien_i;
        slave_d = cfg_slave_i;
      end
    end else begin
      if (stop_i) begin
        stop_pend_d = 1'b1;
      end

      if (!cyc_q) begin
        cyc_d = 1'b1;
        tmo_d = '0;
        case (state_q)
          ST_WR_CTRL0, ST_WR_STOP: begin
            adr_d = CTRL_ADR;
            dat_d = ctrl_dis;
            we_d  = 1'b1;
          end
          ST_WR_MOD: begin
            adr_d = MOD_ADR;
            dat_d = mod_word;
            we_d  = 1'b1;
          end
          ST_RD_MOD: begin
            adr_d = MOD_ADR;
            dat_d = '0;
            we_d  = 1'b0;
          end
          ST_WR_CTRL1: begin
            adr_d = CTRL_ADR;
            dat_d = ctrl_en;
            we_d  = 1'b1;
          end
          default: begin
            cyc_d = 1'b0;
          end
        endcase
      end else if (m_ack_i) begin
        cyc_d = 1'b0;
        we_d  = 1'b0;
        adr_d = '0;
        dat_d = '0;
        case (state_q)
          ST_WR_CTRL0: state_d = ST_WR_MOD;
          ST_WR_MOD:   state_d = ST_RD_MOD;
          ST_RD_MOD: begin
            if (m_dat_i[COUNT_SIZE-1:0] != mod_q) begin
              err_d   = 1'b1;
              seq_end = 1'b1;
            end else begin
              state_d = ST_WR_CTRL1;
            end
          end
          default:     seq_end = 1'b1;
        endcase
      end else if (tmo_q == TMO_LAST) begin
        // Slave never answered: abandon this transfer and the rest of the sequence.
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        adr_d   = '0;
        dat_d   = '0;
        err_d   = 1'b1;
        seq_end = 1'b1;
      end else begin
        tmo_d = tmo_q + 8'd1;
      end

      // A pending stop chains straight into WR_STOP; done is reserved for the final return.
      if (seq_end) begin
        if (stop_pend_d) begin
          state_d     = ST_WR_STOP;
          stop_pend_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  // Outputs straight from registers; byte selects are always both lanes.
  always_comb begin
    busy_o  = (state_q != ST_IDLE);
    done_o  = done_q;
    err_o   = err_q;
    m_cyc_o = cyc_q;
    m_stb_o = cyc_q;
    m_we_o  = we_q;
    m_adr_o = adr_q;
    m_dat_o = dat_q;
    m_sel_o = 2'b11;
  end

endmodule
